// File: rtl/mist_spi_pkg.sv
// rtl/mist_spi_pkg.sv - shared types and user_io command constants for the MiST SPI host
package mist_spi_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_HOLD,
    ST_GAP
  } spi_state_t;

  // user_io command bytes understood by the core-side io-controller
  localparam logic [BYTE_W-1:0] UIO_BUT_SW      = 8'h01;
  localparam logic [BYTE_W-1:0] UIO_JOYSTICK0   = 8'h02;
  localparam logic [BYTE_W-1:0] UIO_JOYSTICK1   = 8'h03;
  localparam logic [BYTE_W-1:0] UIO_MOUSE       = 8'h04;
  localparam logic [BYTE_W-1:0] UIO_KEYBOARD    = 8'h05;
  localparam logic [BYTE_W-1:0] UIO_GET_STRING  = 8'h14;
  localparam logic [BYTE_W-1:0] UIO_SET_STATUS  = 8'h15;
  localparam logic [BYTE_W-1:0] UIO_SET_STATUS2 = 8'h1E;

endpackage

// File: rtl/mist_spi_shifter.sv
// rtl/mist_spi_shifter.sv - mode-0 bit engine: SCK phase counter, bit counter, shared tx/rx shift register
module mist_spi_shifter
  import mist_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_data,
  input  logic [BYTE_W-1:0] next_data,
  input  logic              miso,
  output logic              sck,
  output logic              mosi,
  output logic              sck_rise,
  output logic              sck_fall,
  output logic              byte_done,
  output logic              byte_done_next,
  output logic [BYTE_W-1:0] rx_byte
);

  logic [7:0]        phase;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] shreg;
  logic              miso_q;
  logic              phase_end;
  logic              last_bit;

  assign phase_end = (phase == 8'(CLK_DIV - 1));
  assign last_bit  = (bit_cnt == 3'd7);
  assign sck_rise  = run && phase_end && !sck;
  assign sck_fall  = run && phase_end && sck;
  assign byte_done = sck_fall && last_bit;
  // True one cycle ahead of byte_done so the host can register tx_ready.
  assign byte_done_next = run && last_bit &&
                          ((CLK_DIV == 1) ? !sck : (sck && (phase == 8'(CLK_DIV - 2))));
  assign mosi    = shreg[BYTE_W-1];
  assign rx_byte = {shreg[BYTE_W-2:0], miso_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      phase   <= '0;
      sck     <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
      miso_q  <= 1'b0;
    end else if (load) begin
      phase   <= '0;
      sck     <= 1'b0;
      bit_cnt <= '0;
      shreg   <= load_data;
    end else if (run) begin
      if (phase_end) begin
        phase <= '0;
        sck   <= !sck;
        if (!sck) begin
          miso_q <= miso;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
          shreg   <= last_bit ? next_data : {shreg[BYTE_W-2:0], miso_q};
        end
      end else begin
        phase <= phase + 8'd1;
      end
    end
  end

endmodule

// File: rtl/mist_spi_host.sv
// rtl/mist_spi_host.sv - SPI master playing the ARM side of the MiST user_io link
module mist_spi_host
  import mist_spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int SS_GAP  = 4
) (
  input  logic              CLOCK_27,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [BYTE_W-1:0] cmd_byte,
  input  logic [BYTE_W-1:0] cmd_len,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_ready,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_ss_n
);

  spi_state_t        state;
  logic [7:0]        remaining;
  logic [7:0]        cnt;
  logic              cmd_phase;
  logic              run;
  logic              load;
  logic              sck_rise;
  logic              sck_fall;
  logic              byte_done;
  logic              byte_done_next;
  logic [BYTE_W-1:0] next_data;
  logic [BYTE_W-1:0] rx_byte;

  assign run       = (state == ST_SETUP) || (state == ST_SHIFT_LO) || (state == ST_SHIFT_HI);
  assign load      = (state == ST_IDLE) && cmd_valid;
  // Zero is shifted in after the final byte so MOSI rests low.
  assign next_data = (remaining != 8'd0) ? tx_data : '0;

  mist_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk            (CLOCK_27),
    .reset          (reset),
    .run            (run),
    .load           (load),
    .load_data      (cmd_byte),
    .next_data      (next_data),
    .miso           (spi_miso),
    .sck            (spi_sck),
    .mosi           (spi_mosi),
    .sck_rise       (sck_rise),
    .sck_fall       (sck_fall),
    .byte_done      (byte_done),
    .byte_done_next (byte_done_next),
    .rx_byte        (rx_byte)
  );

  always_ff @(posedge CLOCK_27) begin
    if (reset) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      spi_ss_n  <= 1'b1;
      tx_ready  <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      remaining <= '0;
      cnt       <= '0;
      cmd_phase <= 1'b0;
    end else begin
      tx_ready <= byte_done_next && (remaining != 8'd0);
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            state     <= ST_SETUP;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            spi_ss_n  <= 1'b0;
            remaining <= cmd_len;
            cmd_phase <= 1'b1;
          end
        end
        ST_SETUP, ST_SHIFT_LO: begin
          if (sck_rise) state <= ST_SHIFT_HI;
        end
        ST_SHIFT_HI: begin
          if (sck_fall) begin
            state <= ST_SHIFT_LO;
            if (byte_done) begin
              cmd_phase <= 1'b0;
              if (!cmd_phase) begin
                rx_data  <= rx_byte;
                rx_valid <= 1'b1;
              end
              if (remaining != 8'd0) begin
                remaining <= remaining - 8'd1;
              end else begin
                state <= ST_HOLD;
                cnt   <= '0;
              end
            end
          end
        end
        ST_HOLD: begin
          if (cnt == 8'(CLK_DIV - 1)) begin
            state    <= ST_GAP;
            spi_ss_n <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_GAP: begin
          if (cnt == 8'(SS_GAP - 1)) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mist_spi_host.sv
// tb/tb_mist_spi_host.sv - directed bench for mist_spi_host with a mode-0 slave model and a loopback instance
module tb_mist_spi_host;
  import mist_spi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance a: CLK_DIV=2 with scripted slave; instance b: CLK_DIV=1 with MISO looped to MOSI
  logic       a_reset = 1'b1, a_cmd_valid = 1'b0, a_cmd_ready, a_tx_ready, a_rx_valid, a_busy;
  logic       a_sck, a_mosi, a_miso = 1'b0, a_ss_n;
  logic [7:0] a_cmd_byte = '0, a_cmd_len = '0, a_tx_data = '0, a_rx_data;
  logic       b_reset = 1'b1, b_cmd_valid = 1'b0, b_cmd_ready, b_tx_ready, b_rx_valid, b_busy;
  logic       b_sck, b_mosi, b_miso, b_ss_n;
  logic [7:0] b_cmd_byte = '0, b_cmd_len = '0, b_tx_data = '0, b_rx_data;
  assign b_miso = b_mosi;

  mist_spi_host #(.CLK_DIV(2), .SS_GAP(4)) dut_a (
    .CLOCK_27(clk), .reset(a_reset), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_byte(a_cmd_byte), .cmd_len(a_cmd_len), .tx_data(a_tx_data), .tx_ready(a_tx_ready),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .busy(a_busy), .spi_sck(a_sck),
    .spi_mosi(a_mosi), .spi_miso(a_miso), .spi_ss_n(a_ss_n));

  mist_spi_host #(.CLK_DIV(1), .SS_GAP(4)) dut_b (
    .CLOCK_27(clk), .reset(b_reset), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_byte(b_cmd_byte), .cmd_len(b_cmd_len), .tx_data(b_tx_data), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .busy(b_busy), .spi_sck(b_sck),
    .spi_mosi(b_mosi), .spi_miso(b_miso), .spi_ss_n(b_ss_n));

  // instance a monitor and slave
  logic [23:0] a_sl_pat = '0;
  logic [15:0] a_tx_pat = '0;
  logic [31:0] a_mosi_bits = '0;
  logic [15:0] a_rx_log = '0;
  logic a_sck_p = 1'b0, a_ss_p = 1'b1, a_rdy_p = 1'b0;
  int a_ss_low = 0, a_rises = 0, a_falls = 0, a_tx_cnt = 0, a_rx_cnt = 0;
  int a_tx_idx = 0, a_rx_idx = 0, a_tx_gap_err = 0, a_rx_gap_err = 0, a_busy_err = 0;
  int a_last_tx = 0, a_last_rx = 0, a_ss_rise_cyc = 0, a_rdy_rise_cyc = 0, a_high_gap = 0, a_sl_idx = 0;

  always @(negedge clk) begin
    if (!a_ss_n) a_ss_low++;
    if (a_sck && !a_sck_p) begin
      a_rises++;
      a_mosi_bits = {a_mosi_bits[30:0], a_mosi};
    end
    if (a_ss_n && !a_ss_p) a_ss_rise_cyc = cyc;
    if (!a_ss_n && a_ss_p) begin
      a_falls++;
      a_high_gap = cyc - a_ss_rise_cyc;
    end
    if (a_cmd_ready && !a_rdy_p) a_rdy_rise_cyc = cyc;
    if (!a_reset && (a_busy === a_cmd_ready)) a_busy_err++;
    if (a_ss_n) begin
      a_tx_idx = 0;
      a_rx_idx = 0;
    end
    if (a_tx_ready) begin
      if (a_tx_idx > 0 && (cyc - a_last_tx) != 32) a_tx_gap_err++;
      a_last_tx = cyc;
      a_tx_data = (a_tx_idx == 0) ? a_tx_pat[15:8] : a_tx_pat[7:0];
      a_tx_idx++;
      a_tx_cnt++;
    end
    if (a_rx_valid) begin
      if (a_rx_idx > 0 && (cyc - a_last_rx) != 32) a_rx_gap_err++;
      a_last_rx = cyc;
      a_rx_log = {a_rx_log[7:0], a_rx_data};
      a_rx_idx++;
      a_rx_cnt++;
    end
    if (a_ss_n) a_sl_idx = 0;
    else if (a_sck_p && !a_sck) a_sl_idx++;
    a_miso = (a_sl_idx < 24) ? a_sl_pat[23 - a_sl_idx] : 1'b0;
    a_sck_p = a_sck;
    a_ss_p = a_ss_n;
    a_rdy_p = a_cmd_ready;
  end

  // instance b monitor: loopback means byte k read back equals byte k sent (= k)
  int b_ss_low = 0, b_tx_cnt = 0, b_rx_cnt = 0, b_tx_idx = 0, b_rx_idx = 0;
  int b_tx_gap_err = 0, b_rx_gap_err = 0, b_rx_err = 0, b_last_tx = 0, b_last_rx = 0;

  always @(negedge clk) begin
    if (!b_ss_n) b_ss_low++;
    if (b_ss_n) begin
      b_tx_idx = 0;
      b_rx_idx = 0;
    end
    if (b_tx_ready) begin
      if (b_tx_idx > 0 && (cyc - b_last_tx) != 16) b_tx_gap_err++;
      b_last_tx = cyc;
      b_tx_data = 8'(b_tx_idx);
      b_tx_idx++;
      b_tx_cnt++;
    end
    if (b_rx_valid) begin
      if (b_rx_idx > 0 && (cyc - b_last_rx) != 16) b_rx_gap_err++;
      if (b_rx_data !== 8'(b_rx_idx)) b_rx_err++;
      b_last_rx = cyc;
      b_rx_idx++;
      b_rx_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_a(input logic [7:0] cb, input logic [7:0] cl);
    chk("a_ready_before_accept", 32'(a_cmd_ready), 1);
    a_cmd_byte = cb;
    a_cmd_len = cl;
    a_cmd_valid = 1'b1;
    @(negedge clk);
    a_cmd_valid = 1'b0;
  endtask

  task automatic wait_a_done(input int bound);
    for (int i = 0; i < bound && !a_cmd_ready; i++) @(negedge clk);
    @(negedge clk);
    chk("a_done_in_time", 32'(a_cmd_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  int base_low, base_tx, base_rx, base_f, base_r;

  initial begin
    // 1: reset values
    repeat (3) @(negedge clk);
    a_reset = 1'b0;
    b_reset = 1'b0;
    @(negedge clk);
    chk("rst_ss_n", 32'(a_ss_n), 1);
    chk("rst_sck", 32'(a_sck), 0);
    chk("rst_mosi", 32'(a_mosi), 0);
    chk("rst_tx_ready", 32'(a_tx_ready), 0);
    chk("rst_rx_valid", 32'(a_rx_valid), 0);
    chk("rst_rx_data", 32'(a_rx_data), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_cmd_ready", 32'(a_cmd_ready), 1);
    chk("rst_b_cmd_ready", 32'(b_cmd_ready), 1);

    // 2: command only, 0x14
    base_low = a_ss_low; base_tx = a_tx_cnt; base_rx = a_rx_cnt; base_r = a_rises;
    start_a(UIO_GET_STRING, 8'd0);
    wait_a_done(200);
    chk("t2_ss_low", a_ss_low - base_low, 34);
    chk("t2_rises", a_rises - base_r, 8);
    chk("t2_mosi", a_mosi_bits & 32'hFF, 32'h14);
    chk("t2_tx_pulses", a_tx_cnt - base_tx, 0);
    chk("t2_rx_pulses", a_rx_cnt - base_rx, 0);
    chk("t2_ready_after_ss", a_rdy_rise_cyc - a_ss_rise_cyc, 4);

    // 3: two payload bytes against the scripted slave
    a_sl_pat = {8'hFF, 8'h5A, 8'hC3};
    a_tx_pat = 16'hA53C;
    base_low = a_ss_low; base_tx = a_tx_cnt; base_rx = a_rx_cnt; base_r = a_rises;
    start_a(UIO_SET_STATUS2, 8'd2);
    wait_a_done(300);
    chk("t3_mosi", a_mosi_bits & 32'hFF_FFFF, 32'h1E_A53C);
    chk("t3_rises", a_rises - base_r, 24);
    chk("t3_rx_pulses", a_rx_cnt - base_rx, 2);
    chk("t3_rx_data", 32'(a_rx_log), 32'h5AC3);
    chk("t3_rx_spacing_err", a_rx_gap_err, 0);
    chk("t3_tx_pulses", a_tx_cnt - base_tx, 2);
    chk("t3_tx_spacing_err", a_tx_gap_err, 0);
    chk("t3_ss_low", a_ss_low - base_low, 98);

    // 4: cmd_valid held across two back-to-back transactions
    base_f = a_falls;
    a_cmd_byte = UIO_BUT_SW;
    a_cmd_len = 8'd0;
    a_cmd_valid = 1'b1;
    for (int i = 0; i < 400 && (a_falls - base_f) < 2; i++) @(negedge clk);
    a_cmd_valid = 1'b0;
    chk("t4_two_accepts", a_falls - base_f, 2);
    wait_a_done(200);
    chk("t4_no_extra_accept", a_falls - base_f, 2);
    chk("t4_ss_high_gap_ge_4", 32'(a_high_gap >= 4), 1);
    chk("t4_busy_vs_ready_err", a_busy_err, 0);

    // 5: reset at bit 4 of the first payload byte, then a clean transaction
    a_sl_pat = {8'hFF, 8'h96, 8'h00};
    a_tx_pat = 16'h8100;
    base_tx = a_tx_cnt; base_rx = a_rx_cnt; base_r = a_rises;
    start_a(UIO_SET_STATUS, 8'd2);
    for (int i = 0; i < 200 && (a_rises - base_r) < 12; i++) @(negedge clk);
    chk("t5_reached_bit4", a_rises - base_r, 12);
    a_reset = 1'b1;
    @(negedge clk);
    chk("t5_ss_n", 32'(a_ss_n), 1);
    chk("t5_sck", 32'(a_sck), 0);
    chk("t5_busy", 32'(a_busy), 0);
    chk("t5_rx_valid", 32'(a_rx_valid), 0);
    chk("t5_rx_data", 32'(a_rx_data), 0);
    chk("t5_tx_pulses", a_tx_cnt - base_tx, 1);
    a_reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("t5_no_rx_after_abort", a_rx_cnt - base_rx, 0);
    base_rx = a_rx_cnt;
    start_a(UIO_SET_STATUS, 8'd1);
    wait_a_done(200);
    chk("t5_new_rx_pulses", a_rx_cnt - base_rx, 1);
    chk("t5_new_rx_data", 32'(a_rx_log[7:0]), 32'h96);
    chk("t5_new_mosi", a_mosi_bits & 32'hFFFF, 32'h1581);

    // 6: CLK_DIV=1, 255 payload bytes looped back
    base_low = b_ss_low; base_tx = b_tx_cnt; base_rx = b_rx_cnt;
    chk("t6_b_ready", 32'(b_cmd_ready), 1);
    b_cmd_byte = UIO_JOYSTICK0;
    b_cmd_len = 8'd255;
    b_cmd_valid = 1'b1;
    @(negedge clk);
    b_cmd_valid = 1'b0;
    for (int i = 0; i < 6000 && !b_cmd_ready; i++) @(negedge clk);
    @(negedge clk);
    chk("t6_done_in_time", 32'(b_cmd_ready), 1);
    chk("t6_tx_pulses", b_tx_cnt - base_tx, 255);
    chk("t6_rx_pulses", b_rx_cnt - base_rx, 255);
    chk("t6_tx_spacing_err", b_tx_gap_err, 0);
    chk("t6_rx_spacing_err", b_rx_gap_err, 0);
    chk("t6_loopback_err", b_rx_err, 0);
    chk("t6_ss_low", b_ss_low - base_low, 4097);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
